// File: rtl/axi_rdata_buf.sv
// AXI read-data channel buffer: parametrised FIFO with a registered output beat,
// burst counting and an optional store-and-forward release gate.
module axi_rdata_buf #(
  parameter int ID_W      = 4,
  parameter int DATA_W    = 32,
  parameter int USER_W    = 2,
  parameter int DEPTH     = 256,
  parameter int STORE_FWD = 0,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ID_W-1:0]   in_rid,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic [1:0]        in_rresp,
  input  logic [USER_W-1:0] in_ruser,
  input  logic              in_rlast,
  input  logic              in_mrvalid,
  output logic              out_mrready,
  output logic [ID_W-1:0]   out_rid,
  output logic [DATA_W-1:0] out_rdata,
  output logic [1:0]        out_rresp,
  output logic [USER_W-1:0] out_ruser,
  output logic              out_rlast,
  output logic              out_srvalid,
  input  logic              in_srready,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  bursts
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = 1 + USER_W + 2 + DATA_W + ID_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {FILL, DRAIN} rel_state_t;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] level_next;
  logic [CNT_W-1:0] stored_bursts;
  logic             rdy_q;
  rel_state_t       state, state_next;
  logic             wr_en, pop, load, release_ok, fsm_release;
  logic [W-1:0]     head;

  // Ready is a flop so it is low throughout reset and never depends on app-side inputs.
  assign out_mrready = rdy_q;
  assign wr_en       = in_mrvalid & rdy_q;
  assign pop         = out_srvalid & in_srready;
  assign head        = mem[rd_ptr];
  assign release_ok  = (STORE_FWD == 0) ? 1'b1 : fsm_release;
  assign load        = (level != '0) & release_ok & (~out_srvalid | in_srready);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    level_next = level;
    if (wr_en && !load)
      level_next = level + CNT_W'(1);
    else if (!wr_en && load)
      level_next = level - CNT_W'(1);
  end

  // Release gate: FILL waits for a whole burst (or a full buffer), DRAIN streams to RLAST.
  // A single-beat burst loaded in FILL has already ended, so it stays in FILL.
  always_comb begin
    state_next  = state;
    fsm_release = 1'b1;
    case (state)
      FILL: begin
        fsm_release = (stored_bursts != '0) || (level == FULL);
        if (load && !head[W-1]) state_next = DRAIN;
      end
      DRAIN: begin
        if (load && head[W-1]) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // NOTE: the storage array has no reset; pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_rlast, in_ruser, in_rresp, in_rdata, in_rid};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      rdy_q         <= 1'b0;
      stored_bursts <= '0;
      bursts        <= '0;
      state         <= FILL;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (load)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      rdy_q <= (level_next != FULL);
      state <= state_next;
      case ({wr_en & in_rlast, load & head[W-1]})
        2'b10:   stored_bursts <= stored_bursts + CNT_W'(1);
        2'b01:   stored_bursts <= stored_bursts - CNT_W'(1);
        default: stored_bursts <= stored_bursts;
      endcase
      case ({wr_en & in_rlast, pop & out_rlast})
        2'b10:   bursts <= bursts + CNT_W'(1);
        2'b01:   bursts <= bursts - CNT_W'(1);
        default: bursts <= bursts;
      endcase
    end
  end

  // Output beat: loads on a permitted release, holds under backpressure; a bare pop
  // drops valid and RLAST so a stale RLAST never lingers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out_rid     <= '0;
      out_rdata   <= '0;
      out_rresp   <= '0;
      out_ruser   <= '0;
      out_rlast   <= 1'b0;
      out_srvalid <= 1'b0;
    end else if (load) begin
      {out_rlast, out_ruser, out_rresp, out_rdata, out_rid} <= head;
      out_srvalid <= 1'b1;
    end else if (pop) begin
      out_srvalid <= 1'b0;
      out_rlast   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_rdata_buf.sv
// Directed bench for axi_rdata_buf: a cut-through and a store-and-forward
// instance (both DEPTH=4) driven from per-feature tasks.
module tb_axi_rdata_buf;

  logic       clk = 1'b0;
  logic       reset_;
  logic [3:0]  rid     [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic [1:0]  ruser   [2];
  logic        rlast   [2];
  logic        mrvalid [2];
  logic        srready [2];
  logic        mrready [2];
  logic [3:0]  o_rid   [2];
  logic [31:0] o_rdata [2];
  logic [1:0]  o_rresp [2];
  logic [1:0]  o_ruser [2];
  logic        o_rlast [2];
  logic        o_srvalid [2];
  logic [2:0]  lvl     [2];
  logic [2:0]  brs     [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_rdata_buf #(.ID_W(4), .DATA_W(32), .USER_W(2), .DEPTH(4), .STORE_FWD(0)) u_ct (
    .clk(clk), .reset_(reset_),
    .in_rid(rid[0]), .in_rdata(rdata[0]), .in_rresp(rresp[0]), .in_ruser(ruser[0]),
    .in_rlast(rlast[0]), .in_mrvalid(mrvalid[0]), .out_mrready(mrready[0]),
    .out_rid(o_rid[0]), .out_rdata(o_rdata[0]), .out_rresp(o_rresp[0]), .out_ruser(o_ruser[0]),
    .out_rlast(o_rlast[0]), .out_srvalid(o_srvalid[0]), .in_srready(srready[0]),
    .level(lvl[0]), .bursts(brs[0])
  );

  axi_rdata_buf #(.ID_W(4), .DATA_W(32), .USER_W(2), .DEPTH(4), .STORE_FWD(1)) u_sf (
    .clk(clk), .reset_(reset_),
    .in_rid(rid[1]), .in_rdata(rdata[1]), .in_rresp(rresp[1]), .in_ruser(ruser[1]),
    .in_rlast(rlast[1]), .in_mrvalid(mrvalid[1]), .out_mrready(mrready[1]),
    .out_rid(o_rid[1]), .out_rdata(o_rdata[1]), .out_rresp(o_rresp[1]), .out_ruser(o_ruser[1]),
    .out_rlast(o_rlast[1]), .out_srvalid(o_srvalid[1]), .in_srready(srready[1]),
    .level(lvl[1]), .bursts(brs[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int d, input bit v, input int idx, input logic [31:0] base,
                          input bit lst);
    mrvalid[d] = v;
    rdata[d]   = v ? base + 32'(idx) : '0;
    rid[d]     = v ? 4'(idx) : '0;
    rresp[d]   = v ? 2'(idx) : '0;
    ruser[d]   = v ? 2'(idx + 1) : '0;
    rlast[d]   = v & lst;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      set_beat(d, 1'b0, 0, '0, 1'b0);
      srready[d] = 1'b0;
    end
    reset_ = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mrready[d] !== 1'b0) begin
        errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", d, mrready[d]);
      end
      checks++;
      if (o_srvalid[d] !== 1'b0 || o_rlast[d] !== 1'b0 || o_rdata[d] !== 32'h0) begin
        errors++; $display("FAIL reset_out[%0d]: got v=%b l=%b d=%h expected 0/0/0",
                           d, o_srvalid[d], o_rlast[d], o_rdata[d]);
      end
      checks++;
      if (lvl[d] !== 3'd0 || brs[d] !== 3'd0) begin
        errors++; $display("FAIL reset_cnt[%0d]: got level=%0d bursts=%0d expected 0/0",
                           d, lvl[d], brs[d]);
      end
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset_ = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mrready[d] !== 1'b1) begin
        errors++; $display("FAIL reset_release_ready[%0d]: got %b expected 1", d, mrready[d]);
      end
    end
  endtask

  task automatic test_cut_through();
    logic exp_v;
    srready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_beat(0, 1'b1, i, 32'h10, i == 3);
      else       set_beat(0, 1'b0, 0, '0, 1'b0);
      tick();
      exp_v = (i >= 1 && i <= 4);
      checks++;
      if (o_srvalid[0] !== exp_v) begin
        errors++; $display("FAIL ct_valid[%0d]: got %b expected %b", i, o_srvalid[0], exp_v);
      end
      if (exp_v) begin
        checks++;
        if (o_rdata[0] !== 32'h10 + 32'(i - 1) || o_rlast[0] !== (i == 4)) begin
          errors++; $display("FAIL ct_beat[%0d]: got %h last=%b expected %h last=%b",
                             i, o_rdata[0], o_rlast[0], 32'h10 + 32'(i - 1), i == 4);
        end
      end
      checks++;
      if (lvl[0] !== ((i <= 3) ? 3'd1 : 3'd0) || brs[0] !== ((i == 3 || i == 4) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL ct_cnt[%0d]: got level=%0d bursts=%0d expected %0d/%0d",
                           i, lvl[0], brs[0], (i <= 3) ? 1 : 0, (i == 3 || i == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    srready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_beat(0, 1'b1, i, 32'h20, i == 4);
      tick();
      checks++;
      if (lvl[0] !== ((i == 0) ? 3'd1 : 3'(i))) begin
        errors++; $display("FAIL bp_level[%0d]: got %0d expected %0d", i, lvl[0], (i == 0) ? 1 : i);
      end
      if (i >= 1) begin
        checks++;
        if (o_srvalid[0] !== 1'b1 || o_rdata[0] !== 32'h20) begin
          errors++; $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 20", i, o_srvalid[0], o_rdata[0]);
        end
      end
    end
    set_beat(0, 1'b0, 0, '0, 1'b0);
    checks++;
    if (mrready[0] !== 1'b0) begin
      errors++; $display("FAIL bp_full_ready: got %b expected 0", mrready[0]);
    end
    tick();
    checks++;
    if (o_rdata[0] !== 32'h20 || lvl[0] !== 3'd4 || mrready[0] !== 1'b0) begin
      errors++; $display("FAIL bp_stable: got %h level=%0d ready=%b expected 20/4/0",
                         o_rdata[0], lvl[0], mrready[0]);
    end
    srready[0] = 1'b1;
    tick();
    checks++;
    if (o_rdata[0] !== 32'h21 || lvl[0] !== 3'd3 || mrready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_release: got %h level=%0d ready=%b expected 21/3/1",
                         o_rdata[0], lvl[0], mrready[0]);
    end
    for (int i = 2; i < 5; i++) begin
      tick();
      checks++;
      if (o_srvalid[0] !== 1'b1 || o_rdata[0] !== 32'h20 + 32'(i) || o_rlast[0] !== (i == 4)) begin
        errors++; $display("FAIL bp_drain[%0d]: got v=%b %h last=%b expected v=1 %h last=%b",
                           i, o_srvalid[0], o_rdata[0], o_rlast[0], 32'h20 + 32'(i), i == 4);
      end
    end
    tick();
    checks++;
    if (o_srvalid[0] !== 1'b0 || o_rlast[0] !== 1'b0 || brs[0] !== 3'd0 || lvl[0] !== 3'd0) begin
      errors++; $display("FAIL bp_empty: got v=%b last=%b bursts=%0d level=%0d expected 0/0/0/0",
                         o_srvalid[0], o_rlast[0], brs[0], lvl[0]);
    end
  endtask

  task automatic test_store_fwd();
    srready[1] = 1'b1;
    set_beat(1, 1'b1, 0, 32'hA0, 1'b0);
    tick();
    set_beat(1, 1'b1, 1, 32'hA0, 1'b0);
    tick();
    set_beat(1, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (o_srvalid[1] !== 1'b0 || lvl[1] !== 3'd2) begin
        errors++; $display("FAIL sf_hold[%0d]: got v=%b level=%0d expected 0/2", i, o_srvalid[1], lvl[1]);
      end
    end
    set_beat(1, 1'b1, 2, 32'hA0, 1'b1);
    tick();
    set_beat(1, 1'b0, 0, '0, 1'b0);
    checks++;
    if (o_srvalid[1] !== 1'b0) begin
      errors++; $display("FAIL sf_last_edge: got v=%b expected 0", o_srvalid[1]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_srvalid[1] !== 1'b1 || o_rdata[1] !== 32'hA0 + 32'(i) || o_rlast[1] !== (i == 2)) begin
        errors++; $display("FAIL sf_beat[%0d]: got v=%b %h last=%b expected v=1 %h last=%b",
                           i, o_srvalid[1], o_rdata[1], o_rlast[1], 32'hA0 + 32'(i), i == 2);
      end
    end
    tick();
    checks++;
    if (o_srvalid[1] !== 1'b0 || brs[1] !== 3'd0) begin
      errors++; $display("FAIL sf_empty: got v=%b bursts=%0d expected 0/0", o_srvalid[1], brs[1]);
    end
  endtask

  // Streams n beats (bursts of blen) and scoreboards order, fields, level and bursts.
  task automatic run_stream(input int d, input int n, input int blen, input bit toggle,
                            input int gate, input logic [31:0] base, input string name);
    int  k = 0, j = 0, rl_acc = 0, rl_pop = 0, max_lvl = 0, cyc = 0;
    bit  acc, pop, pre_valid, lst;
    while (cyc < 200 && !(k == n && j == n && !o_srvalid[d])) begin
      lst = ((k + 1) % blen == 0);
      set_beat(d, k < n, k, base, lst);
      srready[d] = toggle ? cyc[0] : 1'b1;
      acc        = (k < n) && mrready[d];
      pop        = o_srvalid[d] && srready[d];
      pre_valid  = o_srvalid[d];
      if (pop && o_rlast[d]) rl_pop++;
      tick();
      cyc++;
      if (acc) begin
        if (lst) rl_acc++;
        k++;
      end
      if (o_srvalid[d] && (!pre_valid || pop)) begin
        checks++;
        if (o_rdata[d] !== base + 32'(j) || o_rid[d] !== 4'(j) || o_rresp[d] !== 2'(j) ||
            o_ruser[d] !== 2'(j + 1) || o_rlast[d] !== ((j + 1) % blen == 0)) begin
          errors++; $display("FAIL %s_beat[%0d]: got %h id=%h resp=%0d user=%0d last=%b expected %h id=%h last=%b",
                             name, j, o_rdata[d], o_rid[d], o_rresp[d], o_ruser[d], o_rlast[d],
                             base + 32'(j), 4'(j), (j + 1) % blen == 0);
        end
        if (j == 0 && gate > 0) begin
          checks++;
          if (max_lvl < gate) begin
            errors++; $display("FAIL %s_gate: got first beat at peak level %0d expected %0d", name, max_lvl, gate);
          end
        end
        j++;
      end
      if (int'(lvl[d]) > max_lvl) max_lvl = int'(lvl[d]);
      checks++;
      if (int'(lvl[d]) !== k - j || int'(brs[d]) !== rl_acc - rl_pop) begin
        errors++; $display("FAIL %s_cnt[%0d]: got level=%0d bursts=%0d expected %0d/%0d",
                           name, cyc, lvl[d], brs[d], k - j, rl_acc - rl_pop);
      end
    end
    set_beat(d, 1'b0, 0, '0, 1'b0);
    checks++;
    if (j != n || k != n) begin
      errors++; $display("FAIL %s_timeout: got %0d out/%0d in expected %0d", name, j, k, n);
    end
  endtask

  task automatic test_escape();
    run_stream(1, 6, 6, 1'b0, 4, 32'hB0, "escape");
  endtask

  task automatic test_toggle();
    run_stream(0, 12, 6, 1'b1, 0, 32'hC0, "toggle");
  endtask

  task automatic test_async_reset();
    srready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_beat(0, 1'b1, i, 32'hD0, 1'b0);
      tick();
    end
    set_beat(0, 1'b0, 0, '0, 1'b0);
    checks++;
    if (lvl[0] !== 3'd3 || o_srvalid[0] !== 1'b1) begin
      errors++; $display("FAIL ar_pre: got level=%0d v=%b expected 3/1", lvl[0], o_srvalid[0]);
    end
    #2 reset_ = 1'b0;
    #1;
    checks++;
    if (o_srvalid[0] !== 1'b0 || lvl[0] !== 3'd0 || brs[0] !== 3'd0 || mrready[0] !== 1'b0) begin
      errors++; $display("FAIL ar_async: got v=%b level=%0d bursts=%0d ready=%b expected 0/0/0/0",
                         o_srvalid[0], lvl[0], brs[0], mrready[0]);
    end
    @(posedge clk);
    #1 reset_ = 1'b1;
    tick();
    checks++;
    if (mrready[0] !== 1'b1) begin
      errors++; $display("FAIL ar_ready: got %b expected 1", mrready[0]);
    end
    run_stream(0, 3, 3, 1'b0, 0, 32'hE0, "fresh");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cut_through();
    test_backpressure();
    test_store_fwd();
    test_escape();
    test_toggle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rdata_buf.md
Name: axi_rdata_buf

Overview:
Parametrised single-clock AXI read-data channel buffer between the memory controller (mem side) and the app/interconnect (app side). It generalises the read-data FIFO to configurable ID/data/user widths and depth, and sustains one beat per cycle. It is burst-aware: it counts complete bursts held in the buffer. A store-and-forward mode releases a burst only after its RLAST beat has arrived, with a deadlock escape when the buffer fills.

Parameters:
ID_W, 4, RID/output ID width
DATA_W, 32, RDATA width
USER_W, 2, RUSER width
DEPTH, 256, storage entries (power of 2, >=4), excluding output register
STORE_FWD, 0, 0 = cut-through, 1 = store-and-forward per burst
CNT_W, $clog2(DEPTH+1), width of level/burst counters

Ports:
clk  in  1  single clock for both sides
reset_  in  1  asynchronous active-low reset
in_rid  in  ID_W  mem-side RID
in_rdata  in  DATA_W  mem-side RDATA
in_rresp  in  2  mem-side RRESP
in_ruser  in  USER_W  mem-side RUSER
in_rlast  in  1  mem-side RLAST
in_mrvalid  in  1  mem-side RVALID
out_mrready  out  1  RREADY back to memory controller
out_rid  out  ID_W  app-side RID
out_rdata  out  DATA_W  app-side RDATA
out_rresp  out  2  app-side RRESP
out_ruser  out  USER_W  app-side RUSER
out_rlast  out  1  app-side RLAST
out_srvalid  out  1  app-side RVALID
in_srready  in  1  app-side RREADY
level  out  CNT_W  entries in storage (excludes output register)
bursts  out  CNT_W  complete bursts (RLAST beats) in storage plus output register

Behaviour:
- Reset: reset_ low asynchronously clears rd/wr pointers, level, bursts, the output register, out_srvalid, out_rlast and all out_r* fields (all 0). out_mrready is 0 while reset_ is low and 1 in the first cycle after deassertion.
- Write: out_mrready = (level != DEPTH), driven from registered state only. A beat is accepted when in_mrvalid & out_mrready. It is stored the same edge, with fields packed {rlast, ruser, rresp, rdata, rid}.
- Output stage: a single registered beat drives out_r*/out_srvalid. The output register loads from storage when (storage non-empty) & (release permitted) & (~out_srvalid | in_srready). It holds all fields stable while out_srvalid & ~in_srready (AXI stability rule).
- Pop with no new load: out_srvalid -> 0 when out_srvalid & in_srready and no new load occurs. out_r* fields may hold their stale value, except out_rlast, which clears to 0.
- Latency: in cut-through mode, a beat accepted at edge N with an empty buffer presents on out_srvalid at N+1. Throughput is 1 beat/cycle with in_srready held high.
- Release permitted:
  - STORE_FWD=0: always.
  - STORE_FWD=1: state machine, two states:
    - FILL: release only if a complete burst is stored (storage-side burst count > 0), or level == DEPTH (escape). A beat loaded in FILL moves to DRAIN.
    - DRAIN: release freely until the beat with rlast=1 is loaded into the output register, then go to FILL.
    - Escape (level == DEPTH with no complete burst): enter DRAIN and cut through the remainder of that burst.
- Counters:
  - level: +1 on write, -1 on load to output register, unchanged when both occur in the same cycle.
  - bursts: +1 on a write with in_rlast=1, -1 on a pop (out_srvalid & in_srready) with out_rlast=1. Simultaneous events net out.
  - Neither counter wraps, by construction. level saturates at DEPTH via out_mrready.
- Full/empty edges:
  - Write while level == DEPTH is impossible (ready low).
  - At level == DEPTH, a load in cycle N raises out_mrready in cycle N+1.
  - With an empty storage and a pop, the output register empties. Same-cycle write data is not bypassed to the output.
- RRESP/RUSER/RID are passed through unmodified. No reordering: strict FIFO order across IDs.

Test Plan:
- Cut-through, DEPTH=4: write 4-beat burst (rdata 0x10..0x13, rlast on 4th), in_srready=1 -> out beats 0x10..0x13 on consecutive cycles starting 1 cycle after first accept; out_rlast only on 0x13; bursts returns to 0.
- Backpressure: in_srready=0, push 5 beats into DEPTH=4 -> 1 in output register, level=4, out_mrready=0, out_rdata stable. Then in_srready=1 for one cycle -> next beat loaded, out_mrready=1 next cycle.
- STORE_FWD=1: send beats 0xA0,0xA1 (no rlast), idle 10 cycles -> out_srvalid stays 0. Send 0xA2 with rlast -> 0xA0 appears next cycle, followed by 0xA1, 0xA2.
- STORE_FWD=1 escape, DEPTH=4: 6-beat burst -> after level hits 4 the output starts draining. All 6 beats are delivered in order with no deadlock and out_rlast on beat 6.
- Simultaneous: steady stream with in_srready toggling 1/0 every cycle -> no lost or duplicated beats; level/bursts match the reference model each cycle.
- Async reset mid-burst: assert reset_ between edges with level=3 -> out_srvalid=0, level=0, bursts=0 immediately. After release, out_mrready=1 and a fresh burst passes correctly.
